// File: rtl/ucode_sequencer.sv
// ucode_sequencer: multi-cycle microcode sequencer for the cpuy core.
// Accepts one opcode per valid/ready handshake and walks its micro-op steps.
// Optional retired-instruction counter is built when UCODE_RETIRE_CNT_EN is defined.
module ucode_sequencer #(
    parameter int DATA_W = 16,
    parameter int STEP_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [7:0]        opcode,
    input  logic [DATA_W-1:0] w,
    input  logic              carry,
    input  logic              zero,
    input  logic              sign,
    input  logic              stall,
    output logic              uop_valid,
    output logic [STEP_W-1:0] step_index,
    output logic              last_step,
    output logic [7:0]        operand_byte,
    output logic              alu_operation,
    output logic              alu_multibyte_result,
    output logic              jump_operation,
    output logic              jump_condition,
    output logic              mov_operation,
    output logic              destination_w,
    output logic              destination_flags,
    output logic              destination_memory,
    output logic              destination_registers,
    output logic              destination_ports,
    output logic [2:0]        destination_index,
    output logic              stack_operation,
    output logic              stack_direction,
    output logic              illegal_opcode
`ifdef UCODE_RETIRE_CNT_EN
    ,
    output logic [15:0]       retired_count
`endif
);
    localparam int BYTES = DATA_W / 8;

    typedef enum logic {IDLE, EXEC} state_t;

    state_t              state, state_next;
    logic [STEP_W-1:0]   step, step_next;
    logic [7:0]          op_q;
    logic [DATA_W-1:0]   w_q;
    logic [DATA_W-1:0]   w_shift;
    logic                c_q, z_q, s_q;
    logic                illegal_q;
    logic [STEP_W:0]     nsteps;
    logic                final_step;
    logic                advance;
    logic                accept;
    logic                opc_illegal;

    // Class 111 is illegal apart from the 0xFF NOP; a jump with selector 7 is illegal too.
    assign opc_illegal = ((opcode[7:5] == 3'b111) && (opcode != 8'hFF)) ||
                         ((opcode[7:5] == 3'b010) && (opcode[2:0] == 3'b111));

    assign uop_valid      = (state == EXEC);
    assign advance        = uop_valid & ~stall;
    assign final_step     = ({1'b0, step} == (nsteps - 1'b1));
    assign instr_ready    = (state == IDLE) | (advance & final_step);
    assign accept         = instr_valid & instr_ready;
    assign step_index     = step;
    assign last_step      = uop_valid & final_step;
    assign illegal_opcode = illegal_q;
    assign w_shift        = w_q >> {step, 3'b000};

    // State and step register; an abort via reset returns straight to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            step  <= '0;
        end else begin
            state <= state_next;
            step  <= step_next;
        end
    end

    // Next state: a new accept wins over retiring, so back-to-back ops have no bubble.
    always_comb begin
        state_next = state;
        step_next  = step;
        if (accept) begin
            state_next = opc_illegal ? IDLE : EXEC;
            step_next  = '0;
        end else if (advance) begin
            if (final_step) begin
                state_next = IDLE;
                step_next  = '0;
            end else begin
                step_next = step + 1'b1;
            end
        end
    end

    // Instruction latches: the in-flight op ignores later changes on w and the flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q      <= '0;
            w_q       <= '0;
            c_q       <= 1'b0;
            z_q       <= 1'b0;
            s_q       <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= accept & opc_illegal;
            if (accept) begin
                op_q <= opcode;
                w_q  <= w;
                c_q  <= carry;
                z_q  <= zero;
                s_q  <= sign;
            end
        end
    end

    // Step count of the latched instruction class.
    always_comb begin
        case (op_q[7:5])
            3'b001:         nsteps = (STEP_W+1)'(BYTES);
            3'b100, 3'b101: nsteps = (STEP_W+1)'(2);
            3'b110:         nsteps = (STEP_W+1)'(3);
            default:        nsteps = (STEP_W+1)'(1);
        endcase
    end

    // Micro-op decode of (class, step); everything stays 0 while no micro-op is valid.
    always_comb begin
        operand_byte          = '0;
        alu_operation         = 1'b0;
        alu_multibyte_result  = 1'b0;
        jump_operation        = 1'b0;
        jump_condition        = 1'b0;
        mov_operation         = 1'b0;
        destination_w         = 1'b0;
        destination_flags     = 1'b0;
        destination_memory    = 1'b0;
        destination_registers = 1'b0;
        destination_ports     = 1'b0;
        destination_index     = '0;
        stack_operation       = 1'b0;
        stack_direction       = 1'b0;
        if (uop_valid) begin
            if (op_q != 8'hFF) destination_index = op_q[2:0];
            case (op_q[7:5])
                3'b000: begin
                    alu_operation         = 1'b1;
                    destination_registers = 1'b1;
                    destination_flags     = 1'b1;
                    operand_byte          = w_shift[7:0];
                end
                3'b001: begin
                    alu_operation        = 1'b1;
                    alu_multibyte_result = 1'b1;
                    destination_w        = 1'b1;
                    destination_flags    = final_step;
                    operand_byte         = w_shift[7:0];
                end
                3'b010: begin
                    jump_operation = 1'b1;
                    case (op_q[2:0])
                        3'd0:    jump_condition = 1'b1;
                        3'd1:    jump_condition = c_q;
                        3'd2:    jump_condition = z_q;
                        3'd3:    jump_condition = s_q;
                        3'd4:    jump_condition = ~c_q;
                        3'd5:    jump_condition = ~z_q;
                        default: jump_condition = ~s_q;
                    endcase
                end
                3'b011: begin
                    mov_operation = 1'b1;
                    case (op_q[4:3])
                        2'b00:   destination_registers = 1'b1;
                        2'b01:   destination_ports     = 1'b1;
                        2'b10:   destination_memory    = 1'b1;
                        default: destination_w         = 1'b1;
                    endcase
                end
                3'b100: begin
                    if (step == '0) begin
                        stack_operation = 1'b1;
                        stack_direction = 1'b1;
                    end else begin
                        destination_memory = 1'b1;
                    end
                end
                3'b101: begin
                    if (step == '0) stack_operation = 1'b1;
                    else            destination_registers = 1'b1;
                end
                3'b110: begin
                    if (step == '0) begin
                        stack_operation = 1'b1;
                        stack_direction = 1'b1;
                    end else if (step == STEP_W'(1)) begin
                        destination_memory = 1'b1;
                    end else begin
                        jump_operation = 1'b1;
                        jump_condition = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef UCODE_RETIRE_CNT_EN
    // Retired-instruction counter: one count per final-step advance, NOPs included.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    retired_count <= '0;
        else if (advance & final_step) retired_count <= retired_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_ucode_sequencer.sv
// tb_ucode_sequencer: scoreboard bench for ucode_sequencer (DATA_W=16).
// A step-list reference model fills the scoreboard at each accept; a monitor drains it.
module tb_ucode_sequencer;
    localparam int DATA_W = 16;
    localparam int STEP_W = 2;
    localparam int BYTES  = DATA_W / 8;

    typedef struct packed {
        logic              ill;
        logic              vld;
        logic [STEP_W-1:0] step;
        logic              last;
        logic [7:0]        ob;
        logic              alu;
        logic              mb;
        logic              jmp;
        logic              jc;
        logic              mov;
        logic              dw;
        logic              df;
        logic              dm;
        logic              dr;
        logic              dp;
        logic [2:0]        didx;
        logic              stk;
        logic              sdir;
    } uop_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              instr_valid = 1'b0;
    logic              instr_ready;
    logic [7:0]        opcode = '0;
    logic [DATA_W-1:0] w = '0;
    logic              carry = 1'b0, zero = 1'b0, sign = 1'b0;
    logic              stall = 1'b0;
    logic              uop_valid;
    logic [STEP_W-1:0] step_index;
    logic              last_step;
    logic [7:0]        operand_byte;
    logic              alu_operation, alu_multibyte_result, jump_operation, jump_condition;
    logic              mov_operation, destination_w, destination_flags, destination_memory;
    logic              destination_registers, destination_ports;
    logic [2:0]        destination_index;
    logic              stack_operation, stack_direction, illegal_opcode;
`ifdef UCODE_RETIRE_CNT_EN
    logic [15:0]       retired_count;
`endif

    int   checks = 0;
    int   errors = 0;
    uop_t sb[$];
    logic [15:0] model_cnt = '0;
    bit   mon_en = 1'b0;
    int   stall_mode = 0;   // 0: stall low, 1: random stall, 2: driven by the main sequence

    ucode_sequencer #(.DATA_W(DATA_W), .STEP_W(STEP_W)) dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .opcode(opcode), .w(w), .carry(carry), .zero(zero), .sign(sign), .stall(stall),
        .uop_valid(uop_valid), .step_index(step_index), .last_step(last_step),
        .operand_byte(operand_byte), .alu_operation(alu_operation),
        .alu_multibyte_result(alu_multibyte_result), .jump_operation(jump_operation),
        .jump_condition(jump_condition), .mov_operation(mov_operation),
        .destination_w(destination_w), .destination_flags(destination_flags),
        .destination_memory(destination_memory), .destination_registers(destination_registers),
        .destination_ports(destination_ports), .destination_index(destination_index),
        .stack_operation(stack_operation), .stack_direction(stack_direction),
        .illegal_opcode(illegal_opcode)
`ifdef UCODE_RETIRE_CNT_EN
        , .retired_count(retired_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic uop_t sample();
        return {illegal_opcode, uop_valid, step_index, last_step, operand_byte,
                alu_operation, alu_multibyte_result, jump_operation, jump_condition,
                mov_operation, destination_w, destination_flags, destination_memory,
                destination_registers, destination_ports, destination_index,
                stack_operation, stack_direction};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s timed out at %0t", name, $time);
    endtask

    // Reference model: expands one instruction into its list of expected micro-ops.
    task automatic expect_instr(input logic [7:0] op, input logic [DATA_W-1:0] wv,
                                input logic c, input logic z, input logic s);
        uop_t u;
        int n;
        logic [DATA_W-1:0] sh;
        logic [2:0] cls, sel;
        cls = op[7:5];
        sel = op[2:0];
        if ((cls == 3'd7 && op != 8'hFF) || (cls == 3'd2 && sel == 3'd7)) begin
            u = '0;
            u.ill = 1'b1;
            sb.push_back(u);
            return;
        end
        case (cls)
            3'd1:       n = BYTES;
            3'd4, 3'd5: n = 2;
            3'd6:       n = 3;
            default:    n = 1;
        endcase
        for (int k = 0; k < n; k++) begin
            u = '0;
            u.vld  = 1'b1;
            u.step = STEP_W'(k);
            u.last = (k == n - 1);
            u.didx = (op == 8'hFF) ? 3'd0 : sel;
            case (cls)
                3'd0: begin u.alu = 1; u.dr = 1; u.df = 1; u.ob = wv[7:0]; end
                3'd1: begin
                    u.alu = 1; u.mb = 1; u.dw = 1; u.df = (k == n - 1);
                    sh = wv >> (8 * k);
                    u.ob = sh[7:0];
                end
                3'd2: begin
                    u.jmp = 1;
                    case (sel)
                        3'd0: u.jc = 1'b1;
                        3'd1: u.jc = c;
                        3'd2: u.jc = z;
                        3'd3: u.jc = s;
                        3'd4: u.jc = !c;
                        3'd5: u.jc = !z;
                        default: u.jc = !s;
                    endcase
                end
                3'd3: begin
                    u.mov = 1;
                    case (op[4:3])
                        2'd0: u.dr = 1;
                        2'd1: u.dp = 1;
                        2'd2: u.dm = 1;
                        default: u.dw = 1;
                    endcase
                end
                3'd4: if (k == 0) begin u.stk = 1; u.sdir = 1; end else u.dm = 1;
                3'd5: if (k == 0) u.stk = 1; else u.dr = 1;
                3'd6: begin
                    if (k == 0) begin u.stk = 1; u.sdir = 1; end
                    else if (k == 1) u.dm = 1;
                    else begin u.jmp = 1; u.jc = 1; end
                end
                default: ;
            endcase
            sb.push_back(u);
        end
    endtask

    // Monitor: compares every cycle against the scoreboard head, pops on advance.
    initial begin
        uop_t act, head;
        logic exp_rdy;
        forever begin
            @(negedge clk);
            if (mon_en && rst_n) begin
                act = sample();
`ifdef UCODE_RETIRE_CNT_EN
                chk("retired_count", 32'(retired_count), 32'(model_cnt));
`endif
                if (uop_valid || illegal_opcode) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_uop", 32'(act), 32'd0);
                    end else begin
                        head = sb[0];
                        chk("uop", 32'(act), 32'(head));
                        exp_rdy = head.ill ? 1'b1 : (head.last & ~stall);
                        chk("instr_ready", 32'(instr_ready), 32'(exp_rdy));
                        if (head.ill || !stall) begin
                            void'(sb.pop_front());
                            if (!head.ill && head.last) model_cnt = model_cnt + 16'd1;
                        end
                    end
                end else begin
                    chk("idle_outputs", 32'(act), 32'd0);
                    chk("idle_ready", 32'(instr_ready), 32'd1);
                end
            end
        end
    end

    // Stall generator, active when stall_mode is 0 or 1.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (stall_mode == 0)      stall = 1'b0;
            else if (stall_mode == 1) stall = ($urandom_range(0, 3) == 0);
        end
    end

    // Offer one instruction, wait for accept, then disturb w and the flags.
    task automatic send(input logic [7:0] op, input logic [DATA_W-1:0] wv,
                        input logic c, input logic z, input logic s, input bit keep);
        int n;
        n = 0;
        opcode = op; w = wv; carry = c; zero = z; sign = s;
        instr_valid = 1'b1;
        @(negedge clk);
        while (!instr_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (!instr_ready) begin
            timeout("accept");
            @(posedge clk);
            #1;
            instr_valid = 1'b0;
            return;
        end
        expect_instr(op, wv, c, z, s);
        @(posedge clk);
        #1;
        w = ~wv; carry = ~c; zero = ~z; sign = ~s;
        if (!keep) instr_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        @(posedge clk);
        while (sb.size() != 0 && n < 500) begin
            n++;
            @(posedge clk);
        end
        repeat (2) @(posedge clk);
        #1;
        chk("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    task automatic wait_step1();
        int n;
        n = 0;
        while (!(uop_valid && step_index == STEP_W'(1)) && n < 50) begin
            n++;
            @(posedge clk);
            #1;
        end
        if (!(uop_valid && step_index == STEP_W'(1))) timeout("call_step1");
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        logic [7:0] op;
        bit keep;
        // Reset state
        #2;
        chk("reset_outputs", 32'(sample()), 32'd0);
        chk("reset_ready", 32'(instr_ready), 32'd1);
`ifdef UCODE_RETIRE_CNT_EN
        chk("reset_count", 32'(retired_count), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        // Directed: multibyte ALU, jump with flag change, illegal, NOP
        send(8'h22, 16'hBEEF, 1'b0, 1'b0, 1'b0, 1'b0);
        send(8'h45, 16'h1234, 1'b0, 1'b1, 1'b0, 1'b0);
        send(8'hE0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        send(8'hFF, 16'h5A5A, 1'b1, 1'b1, 1'b1, 1'b0);
        wait_drain();

        // Directed: CALL with a 3-cycle stall on step 1
        stall_mode = 2;
        stall = 1'b0;
        send(8'hC0, 16'h0F0F, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_step1();
        stall = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("call_stall_step", 32'(step_index), 32'd1);
        stall = 1'b0;
        stall_mode = 0;
        wait_drain();

        // Directed: PUSH then POP with instr_valid held high, no bubble
        opcode = 8'h80; w = 16'h1111; instr_valid = 1'b1;
        expect_instr(8'h80, 16'h1111, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        opcode = 8'hA3; w = 16'h2222;
        expect_instr(8'hA3, 16'h2222, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("b2b_valid0", 32'(uop_valid), 32'd1);
        @(negedge clk);
        chk("b2b_valid1", 32'(uop_valid), 32'd1);
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        @(negedge clk);
        chk("b2b_valid2", 32'(uop_valid), 32'd1);
        @(negedge clk);
        chk("b2b_valid3", 32'(uop_valid), 32'd1);
        @(posedge clk);
        #1;
        wait_drain();

        // Randomized stream with random stalls and gaps
        stall_mode = 1;
        for (int i = 0; i < 300; i++) begin
            op = 8'($urandom);
            if ($urandom_range(0, 15) == 0) op = 8'hFF;
            keep = (i < 299) && ($urandom_range(0, 1) == 1);
            send(op, DATA_W'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), keep);
            if (!keep && $urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        stall_mode = 0;
        stall = 1'b0;
        wait_drain();

        // Reset asserted during CALL step 1
        send(8'hC0, 16'hCAFE, 1'b1, 1'b0, 1'b1, 1'b0);
        wait_step1();
        mon_en = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_outputs", 32'(sample()), 32'd0);
        chk("abort_ready", 32'(instr_ready), 32'd1);
`ifdef UCODE_RETIRE_CNT_EN
        chk("abort_count", 32'(retired_count), 32'd0);
`endif
        sb.delete();
        model_cnt = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("post_reset_idle", 32'(uop_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
